branch_resolve_unit: RTL and testbench

Resolves up to two branch/jump instructions per cycle at the EX stage, compares each against the prediction issued by the front-end predictor, and generates a registered pipeline flush/redirect on misprediction. It serialises resolved branches through a small FIFO into the predictor's single-entry-per-cycle update port (`ex_branch_type`, `ex_branch_success`, `ex_inst_addr`, `ex_next_inst_addr`, `ex_predict_success`). It sits between the dual-issue EX stage and the branch predictor, and is the update-side counterpart of the predictor.

---
 rtl/branch_resolve_if.sv | 26 ++
 rtl/branch_resolve_unit.sv | 88 ++++++++
 tb/tb_branch_resolve_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: EX-stage resolve inputs, flush/redirect outputs and predictor update port.
interface branch_resolve_if;
  logic        ex_valid1, ex_valid2;
  logic [1:0]  ex_type1, ex_type2;
  logic        ex_taken1, ex_taken2;
  logic [31:0] ex_pc1, ex_pc2, ex_target1, ex_target2;
  logic        ex_pred_happen1, ex_pred_happen2;
  logic [31:0] ex_pred_addr1, ex_pred_addr2;
  logic        flush_o, ex_stall_o, upd_success_o, upd_pred_ok_o;
  logic [31:0] redirect_pc_o, upd_pc_o, upd_next_o;
  logic [1:0]  upd_type_o;
  modport master (
    output ex_valid1, ex_valid2, ex_type1, ex_type2, ex_taken1, ex_taken2,
           ex_pc1, ex_pc2, ex_target1, ex_target2, ex_pred_happen1, ex_pred_happen2,
           ex_pred_addr1, ex_pred_addr2,
    input  flush_o, redirect_pc_o, ex_stall_o, upd_type_o, upd_success_o,
           upd_pc_o, upd_next_o, upd_pred_ok_o
  );
  modport slave (
    input  ex_valid1, ex_valid2, ex_type1, ex_type2, ex_taken1, ex_taken2,
           ex_pc1, ex_pc2, ex_target1, ex_target2, ex_pred_happen1, ex_pred_happen2,
           ex_pred_addr1, ex_pred_addr2,
    output flush_o, redirect_pc_o, ex_stall_o, upd_type_o, upd_success_o,
           upd_pc_o, upd_next_o, upd_pred_ok_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: dual-slot branch resolution, registered flush/redirect, FIFO-serialised predictor updates.
// Defining BRU_STATS_EN adds stat_branches_o / stat_mispredicts_o counters.
module branch_resolve_unit #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  branch_resolve_if.slave bus
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispredicts_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [1:0]  typ;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] nxt;
    logic        ok;
  } entry_t;
  entry_t mem [DEPTH];
  entry_t e1, e2, head, upd;
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic [1:0] n_push;
  logic [31:0] redirect;
  logic tk1, tk2, stall, flush, blocked, live1, live2, mis1, mis2, pop;
  assign stall = cnt > (AW+1)'(DEPTH - 2);
  always_comb begin
    tk1 = bus.ex_type1 == 2'b01 ? bus.ex_taken1 : 1'b1;
    tk2 = bus.ex_type2 == 2'b01 ? bus.ex_taken2 : 1'b1;
    e1 = '{bus.ex_type1, tk1, bus.ex_pc1, tk1 ? bus.ex_target1 : bus.ex_pc1 + 32'd8,
           (bus.ex_pred_happen1 == tk1) && (!tk1 || bus.ex_pred_addr1 == bus.ex_target1)};
    e2 = '{bus.ex_type2, tk2, bus.ex_pc2, tk2 ? bus.ex_target2 : bus.ex_pc2 + 32'd8,
           (bus.ex_pred_happen2 == tk2) && (!tk2 || bus.ex_pred_addr2 == bus.ex_target2)};
    blocked = stall || flush;
    live1 = bus.ex_valid1 && bus.ex_type1 != 2'b00 && !blocked;
    mis1 = live1 && !e1.ok;
    live2 = bus.ex_valid2 && bus.ex_type2 != 2'b00 && !blocked && !mis1;
    mis2 = live2 && !e2.ok;
    n_push = {1'b0, live1} + {1'b0, live2};
    pop = cnt != '0 || n_push != 2'd0;
    // An empty FIFO forwards the first pushed entry straight to the update register
    head = cnt != '0 ? mem[rd] : live1 ? e1 : e2;
  end
  always_ff @(posedge clk) begin
    if (live1) mem[wr] <= e1;
    if (live2) mem[wr + AW'(live1)] <= e2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      upd <= '0;
      flush <= 1'b0;
      redirect <= '0;
    end else begin
      rd <= rd + AW'(pop);
      wr <= wr + AW'(n_push);
      cnt <= cnt + (AW+1)'(n_push) - (AW+1)'(pop);
      upd <= pop ? head : '0;
      flush <= mis1 || mis2;
      redirect <= mis1 ? e1.nxt : mis2 ? e2.nxt : '0;
    end
  end
  assign bus.ex_stall_o = stall;
  assign bus.flush_o = flush;
  assign bus.redirect_pc_o = redirect;
  assign bus.upd_type_o = upd.typ;
  assign bus.upd_success_o = upd.taken;
  assign bus.upd_pc_o = upd.pc;
  assign bus.upd_next_o = upd.nxt;
  assign bus.upd_pred_ok_o = upd.ok;
`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_o <= '0;
      stat_mispredicts_o <= '0;
    end else begin
      stat_branches_o <= stat_branches_o + 32'(n_push);
      stat_mispredicts_o <= stat_mispredicts_o + 32'(mis1 || mis2);
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors, queue scoreboard for updates and redirects.
module tb_branch_resolve_unit;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  branch_resolve_if bus();
`ifdef BRU_STATS_EN
  logic [31:0] stat_br, stat_mis;
`endif
  branch_resolve_unit #(.DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef BRU_STATS_EN
    ,
    .stat_branches_o(stat_br),
    .stat_mispredicts_o(stat_mis)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic v; logic [1:0] typ; logic taken; logic [31:0] pc; logic [31:0] tgt; logic ph; logic [31:0] pa;
  } br_t;
  typedef struct packed {
    logic [1:0] typ; logic taken; logic [31:0] pc; logic [31:0] nxt; logic ok;
  } upd_t;
  localparam br_t IDLE = '0;
  upd_t uq[$];
  logic [31:0] fq[$];
  int m_cnt = 0;
  logic m_flush = 1'b0;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic br_t br(input logic [1:0] typ, input logic taken, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic ph, input logic [31:0] pa);
    br_t b;
    b = '{1'b1, typ, taken, pc, tgt, ph, pa};
    return b;
  endfunction
  function automatic upd_t resolve(input br_t b);
    upd_t u;
    logic tk;
    tk = b.typ == 2'b01 ? b.taken : 1'b1;
    u.typ = b.typ;
    u.taken = tk;
    u.pc = b.pc;
    u.nxt = tk ? b.tgt : b.pc + 32'd8;
    u.ok = (b.ph == tk) && (!tk || b.pa == b.tgt);
    return u;
  endfunction
  task automatic drive(input br_t b1, input br_t b2);
    bus.ex_valid1 = b1.v; bus.ex_type1 = b1.typ; bus.ex_taken1 = b1.taken; bus.ex_pc1 = b1.pc;
    bus.ex_target1 = b1.tgt; bus.ex_pred_happen1 = b1.ph; bus.ex_pred_addr1 = b1.pa;
    bus.ex_valid2 = b2.v; bus.ex_type2 = b2.typ; bus.ex_taken2 = b2.taken; bus.ex_pc2 = b2.pc;
    bus.ex_target2 = b2.tgt; bus.ex_pred_happen2 = b2.ph; bus.ex_pred_addr2 = b2.pa;
  endtask
  task automatic cyc(input br_t b1, input br_t b2, output bit acc);
    upd_t u1, u2;
    logic l1, l2, blk;
    int n;
    @(posedge clk);
    #1;
    chk("stall", bus.ex_stall_o, m_cnt > D - 2);
    drive(b1, b2);
    blk = m_flush || m_cnt > D - 2;
    u1 = resolve(b1);
    u2 = resolve(b2);
    l1 = !blk && b1.v && b1.typ != 2'b00;
    l2 = !blk && b2.v && b2.typ != 2'b00 && !(l1 && !u1.ok);
    if (l1) uq.push_back(u1);
    if (l2) uq.push_back(u2);
    if (l1 && !u1.ok) fq.push_back(u1.nxt);
    else if (l2 && !u2.ok) fq.push_back(u2.nxt);
    m_flush = (l1 && !u1.ok) || (l2 && !u2.ok);
    n = int'(l1) + int'(l2);
    m_cnt = m_cnt + n - ((m_cnt + n) > 0 ? 1 : 0);
    acc = !blk;
  endtask
  task automatic step(input br_t b1, input br_t b2);
    bit a;
    cyc(b1, b2, a);
  endtask
  always @(negedge clk) begin
    if (bus.upd_type_o != 2'b00) begin
      if (uq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL upd_unexpected: got type %0b pc %0h, expected no update", bus.upd_type_o, bus.upd_pc_o);
      end else
        chk("upd", {bus.upd_type_o, bus.upd_success_o, bus.upd_pc_o, bus.upd_next_o, bus.upd_pred_ok_o},
            uq.pop_front());
    end
    if (bus.flush_o) begin
      if (fq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL flush_unexpected: got flush redirect %0h, expected no flush", bus.redirect_pc_o);
      end else
        chk("redirect", bus.redirect_pc_o, fq.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bit acc;
    int i, tries;
    drive(IDLE, IDLE);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_flush", bus.flush_o, 1'b0);
    chk("rst_redirect", bus.redirect_pc_o, 32'h0);
    chk("rst_stall", bus.ex_stall_o, 1'b0);
    chk("rst_upd", {bus.upd_type_o, bus.upd_success_o, bus.upd_pc_o, bus.upd_next_o, bus.upd_pred_ok_o}, 68'h0);
    // correct taken branch
    step(br(2'b01, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200), IDLE);
    step(IDLE, IDLE);
    @(negedge clk);
    chk("t1_flush", bus.flush_o, 1'b0);
    chk("t1_type", bus.upd_type_o, 2'b01);
    chk("t1_next", bus.upd_next_o, 32'h200);
    chk("t1_ok", bus.upd_pred_ok_o, 1'b1);
    // predicted taken, actually not taken
    step(br(2'b01, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200), IDLE);
    step(IDLE, IDLE);
    @(negedge clk);
    chk("t2_flush", bus.flush_o, 1'b1);
    chk("t2_redirect", bus.redirect_pc_o, 32'h108);
    chk("t2_ok", bus.upd_pred_ok_o, 1'b0);
    step(IDLE, IDLE);
    @(negedge clk);
    chk("t2_flush_once", bus.flush_o, 1'b0);
    // slot 1 jump mispredicts, slot 2 dropped
    step(br(2'b11, 1'b0, 32'h100, 32'h400, 1'b1, 32'h300), br(2'b01, 1'b1, 32'h104, 32'h500, 1'b1, 32'h500));
    step(IDLE, IDLE);
    @(negedge clk);
    chk("t3_flush", bus.flush_o, 1'b1);
    chk("t3_redirect", bus.redirect_pc_o, 32'h400);
    chk("t3_upd", {bus.upd_type_o, bus.upd_pc_o}, {2'b11, 32'h100});
    step(IDLE, IDLE);
    @(negedge clk);
    chk("t3_no_slot2", bus.upd_type_o, 2'b00);
    // inputs during the flush cycle are ignored
    step(br(2'b01, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200), IDLE);
    step(br(2'b01, 1'b0, 32'h300, 32'h340, 1'b1, 32'h340), br(2'b11, 1'b1, 32'h304, 32'h600, 1'b0, 32'h0));
    step(IDLE, IDLE);
    @(negedge clk);
    chk("t5_no_flush", bus.flush_o, 1'b0);
    chk("t5_no_upd", bus.upd_type_o, 2'b00);
    // sustained dual issue
    repeat (3) step(IDLE, IDLE);
    i = 0;
    tries = 0;
    while (i < 6 && tries < 30) begin
      cyc(br(2'b01, 1'b0, 32'h1000 + 32'(16 * i), 32'h2000, 1'b0, 32'h0),
          br(2'b01, 1'b0, 32'h1004 + 32'(16 * i), 32'h2000, 1'b0, 32'h0), acc);
      if (tries == 3) chk("t4_stall_cycle3", bus.ex_stall_o, 1'b1);
      if (acc) i++;
      tries++;
    end
    chk("t4_all_issued", i, 6);
    repeat (8) step(IDLE, IDLE);
    // reset with three queued entries and a pending flush
    step(br(2'b01, 1'b0, 32'h3000, 32'h0, 1'b0, 32'h0), br(2'b01, 1'b0, 32'h3004, 32'h0, 1'b0, 32'h0));
    step(br(2'b01, 1'b0, 32'h3010, 32'h0, 1'b0, 32'h0), br(2'b01, 1'b0, 32'h3014, 32'h0, 1'b0, 32'h0));
    step(br(2'b01, 1'b0, 32'h3020, 32'h0, 1'b0, 32'h0), br(2'b01, 1'b1, 32'h3024, 32'h3100, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    chk("t6_pre_stall", bus.ex_stall_o, 1'b1);
    drive(IDLE, IDLE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    uq.delete();
    fq.delete();
    m_cnt = 0;
    m_flush = 1'b0;
    @(negedge clk);
    chk("t6_type", bus.upd_type_o, 2'b00);
    chk("t6_flush", bus.flush_o, 1'b0);
    chk("t6_stall", bus.ex_stall_o, 1'b0);
`ifdef BRU_STATS_EN
    chk("t6_stat_br", stat_br, 32'd0);
    chk("t6_stat_mis", stat_mis, 32'd0);
    step(br(2'b01, 1'b1, 32'h500, 32'h540, 1'b1, 32'h540), br(2'b10, 1'b0, 32'h504, 32'h800, 1'b1, 32'h700));
    step(IDLE, IDLE);
    @(negedge clk);
    chk("stat_br", stat_br, 32'd2);
    chk("stat_mis", stat_mis, 32'd1);
`endif
    repeat (6) step(IDLE, IDLE);
    @(negedge clk);
    chk("upd_drained", uq.size(), 0);
    chk("flush_drained", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
